// File: rtl/time_mode_ctrl.sv
// Alarm-clock mode controller: button strobes -> time-calculator controls, alarm register, ring output.
// Optional snooze state is built when ALARM_SNOOZE_EN is defined.
module time_mode_ctrl #(
    parameter int unsigned VIEW_TICKS   = 100,
    parameter int unsigned RING_TICKS   = 6000,
    parameter int unsigned SNOOZE_TICKS = 30000
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        BTN_MODE,
    input  logic        BTN_UP,
    input  logic        BTN_DOWN,
    input  logic        BTN_OK,
    input  logic [16:0] CUR_TIME,
    output logic [2:0]  FLAG,
    output logic        IS_SAVED_TIME,
    output logic [16:0] IN_TIME,
    output logic [16:0] ALARM_TIME,
    output logic [16:0] EDIT_TIME,
    output logic [1:0]  EDIT_FIELD,
    output logic        ALARM_ARMED,
    output logic        ALARM_RING
);

    // state    | meaning
    // RUN      | clock running, alarm match armed     SET_*/ALM_* | editing time / alarm field
    // VIEW_ALM | alarm shown for VIEW_TICKS           RING/SNOOZE | buzzer on / snooze delay
    typedef enum logic [3:0] {
        S_RUN, S_SET_HR, S_SET_MIN, S_SET_SEC, S_ALM_HR, S_ALM_MIN, S_VIEW_ALM, S_RING
`ifdef ALARM_SNOOZE_EN
        , S_SNOOZE
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] tick_q, tick_d;
    logic [16:0] edit_q, edit_d, in_q, in_d, alarm_q, alarm_d;
    logic        armed_q, armed_d, saved_q, saved_d, guard_q, guard_d, ring_q;
    logic [2:0]  flag_q;
    logic [1:0]  field_q;
    logic        b_mode, b_ok, b_up, b_down, b_any, match_raw, match;
    logic [16:0] stepped;

    function automatic logic [5:0] wrap60(input logic [5:0] v, input logic up);
        if (up) return (v >= 6'd59) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    function automatic logic [16:0] step_field(input logic [16:0] t, input logic [1:0] fld,
                                               input logic up);
        logic [16:0] r;
        r = t;
        case (fld)
            2'd1: begin
                if (up && t[15:12] >= 4'd11) begin
                    r[15:12] = 4'd0;
                    r[16]    = ~t[16];
                end else if (!up && t[15:12] == 4'd0) begin
                    r[15:12] = 4'd11;
                    r[16]    = ~t[16];
                end else begin
                    r[15:12] = up ? t[15:12] + 4'd1 : t[15:12] - 4'd1;
                end
            end
            2'd2:    r[11:6] = wrap60(t[11:6], up);
            2'd3:    r[5:0]  = wrap60(t[5:0], up);
            default: r = t;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] flag_of(input state_t s);
        case (s)
            S_SET_HR, S_SET_MIN, S_SET_SEC: return 3'b010;
            S_ALM_HR, S_ALM_MIN:            return 3'b011;
            S_VIEW_ALM:                     return 3'b001;
            default:                        return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] field_of(input state_t s);
        case (s)
            S_SET_HR, S_ALM_HR:   return 2'd1;
            S_SET_MIN, S_ALM_MIN: return 2'd2;
            S_SET_SEC:            return 2'd3;
            default:              return 2'd0;
        endcase
    endfunction

    assign b_mode    = BTN_MODE;
    assign b_ok      = BTN_OK & ~BTN_MODE;
    assign b_up      = BTN_UP & ~BTN_MODE & ~BTN_OK;
    assign b_down    = BTN_DOWN & ~BTN_MODE & ~BTN_OK & ~BTN_UP;
    assign b_any     = BTN_MODE | BTN_OK | BTN_UP | BTN_DOWN;
    assign match_raw = armed_q && (CUR_TIME[16:6] == alarm_q[16:6]) && (CUR_TIME[5:0] == 6'd0);
    // guard_q blocks a second ring while the same matching second is still presented
    assign match     = match_raw && !guard_q;
    assign stepped   = step_field(edit_q, field_q, b_up);

    always_comb begin
        state_d = state_q;
        edit_d  = edit_q;
        in_d    = in_q;
        alarm_d = alarm_q;
        armed_d = armed_q;
        saved_d = 1'b0;
        guard_d = guard_q & match_raw;
        tick_d  = tick_q + 32'd1;
        case (state_q)
            S_RUN: begin
                if (match) begin
                    state_d = S_RING;
                    guard_d = 1'b1;
                end else if (b_mode) begin
                    state_d = S_SET_HR;
                    edit_d  = CUR_TIME;
                end else if (b_down) begin
                    state_d = S_ALM_HR;
                    edit_d  = alarm_q;
                end else if (b_up) begin
                    state_d = S_VIEW_ALM;
                end
            end
            S_SET_HR, S_SET_MIN, S_SET_SEC: begin
                if (b_mode) begin
                    state_d = (state_q == S_SET_HR)  ? S_SET_MIN :
                              (state_q == S_SET_MIN) ? S_SET_SEC : S_SET_HR;
                end else if (b_ok) begin
                    in_d    = edit_q;
                    saved_d = 1'b1;
                    state_d = S_RUN;
                end else if (b_up || b_down) begin
                    edit_d = stepped;
                end
            end
            S_ALM_HR, S_ALM_MIN: begin
                if (b_mode) begin
                    state_d = (state_q == S_ALM_HR) ? S_ALM_MIN : S_ALM_HR;
                end else if (b_ok) begin
                    alarm_d = {edit_q[16:6], 6'd0};
                    armed_d = 1'b1;
                    state_d = S_RUN;
                end else if (b_up || b_down) begin
                    edit_d = stepped;
                end
            end
            S_VIEW_ALM: begin
                if (b_any || tick_q == VIEW_TICKS - 1) state_d = S_RUN;
            end
            S_RING: begin
                if (b_ok || tick_q == RING_TICKS - 1) state_d = S_RUN;
`ifdef ALARM_SNOOZE_EN
                else if (b_down) state_d = S_SNOOZE;
`endif
            end
`ifdef ALARM_SNOOZE_EN
            S_SNOOZE: begin
                if (b_ok) state_d = S_RUN;
                else if (tick_q == SNOOZE_TICKS - 1) state_d = S_RING;
            end
`endif
            default: state_d = S_RUN;
        endcase
        if (state_d != state_q) tick_d = 32'd0;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_RUN;
            tick_q  <= 32'd0;
            edit_q  <= 17'd0;
            in_q    <= 17'd0;
            alarm_q <= 17'd0;
            armed_q <= 1'b0;
            saved_q <= 1'b0;
            guard_q <= 1'b0;
            ring_q  <= 1'b0;
            flag_q  <= 3'b000;
            field_q <= 2'd0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            edit_q  <= edit_d;
            in_q    <= in_d;
            alarm_q <= alarm_d;
            armed_q <= armed_d;
            saved_q <= saved_d;
            guard_q <= guard_d;
            ring_q  <= (state_d == S_RING);
            flag_q  <= flag_of(state_d);
            field_q <= field_of(state_d);
        end
    end

    assign FLAG          = flag_q;
    assign IS_SAVED_TIME = saved_q;
    assign IN_TIME       = in_q;
    assign ALARM_TIME    = alarm_q;
    assign EDIT_TIME     = edit_q;
    assign EDIT_FIELD    = field_q;
    assign ALARM_ARMED   = armed_q;
    assign ALARM_RING    = ring_q;

endmodule

// File: doc/time_mode_ctrl.md
# time_mode_ctrl

Mode controller that sequences the time-calculation datapath of the alarm clock. It turns single-cycle button strobes into the `FLAG`, `IS_SAVED_TIME`, `IN_TIME` and `ALARM_TIME` controls that the time calculator consumes. It holds the alarm register, detects the alarm match against the running time, and drives the ring output. It sits between the button conditioning logic and the time calculator.

## Interface
- `VIEW_TICKS`, default 100: cycles `VIEW_ALM` is held before returning to `RUN`.
- `RING_TICKS`, default 6000: maximum cycles `ALARM_RING` stays high.
- `SNOOZE_TICKS`, default 30000: snooze delay in cycles (used only with `ALARM_SNOOZE_EN`).
- `CLK` in, 1 bit: single clock, rising edge.
- `RESETN` in, 1 bit: asynchronous, active-low reset.
- `BTN_MODE`, `BTN_UP`, `BTN_DOWN`, `BTN_OK` in, 1 bit each: debounced one-cycle pulses.
- `CUR_TIME` in, 17 bits: running time from the time calculator, `{MERIDIAN, HOUR[3:0], MIN[5:0], SEC[5:0]}`; HOUR is 0..11 and MERIDIAN=1 means PM.
- `FLAG` out, 3 bits: mode to the time calculator. `000` = RUN/RING, `001` = VIEW_ALM, `010` = SET_*, `011` = ALM_*.
- `IS_SAVED_TIME` out, 1 bit: one-cycle commit strobe.
- `IN_TIME` out, 17 bits: committed time, valid when `IS_SAVED_TIME` is high and held afterwards.
- `ALARM_TIME` out, 17 bits: alarm register in the same format; SEC is always 0.
- `EDIT_TIME` out, 17 bits: working copy shown while editing.
- `EDIT_FIELD` out, 2 bits: field being edited, for blinking. 0 = none, 1 = hour, 2 = min, 3 = sec.
- `ALARM_ARMED` out, 1 bit: an alarm is set.
- `ALARM_RING` out, 1 bit: the buzzer drive.

## Operation
- States: `RUN`, `SET_HR`, `SET_MIN`, `SET_SEC`, `ALM_HR`, `ALM_MIN`, `VIEW_ALM`, `RING`, plus `SNOOZE` when `ALARM_SNOOZE_EN` is defined.
- Simultaneous buttons: only the highest-priority button acts; priority is MODE > OK > UP > DOWN.
- `RUN` transitions:
  - MODE → `SET_HR`; `EDIT_TIME` ← `CUR_TIME`.
  - DOWN → `ALM_HR`; `EDIT_TIME` ← `ALARM_TIME`.
  - UP → `VIEW_ALM`.
  - OK is ignored.
- `SET_*` editing:
  - MODE cycles HR → MIN → SEC → HR.
  - UP/DOWN step the selected field by ±1 with wrap: hour 0..11, min/sec 0..59.
  - Hour wrap 11→0 (UP) or 0→11 (DOWN) toggles MERIDIAN.
  - OK: `IN_TIME` ← `EDIT_TIME`, `IS_SAVED_TIME`=1 for one cycle, → `RUN`.
- `ALM_*` editing:
  - MODE toggles HR/MIN; UP/DOWN use the same rules as `SET_*`.
  - OK: `ALARM_TIME` ← `{EDIT_TIME[16:6], 6'd0}`, `ALARM_ARMED`=1, → `RUN`.
- `VIEW_ALM`: exits to `RUN` on any button or after `VIEW_TICKS` cycles. The button that exits is consumed and has no other effect.
- Alarm match:
  - Condition: state is `RUN`, `ALARM_ARMED`=1, `CUR_TIME[16:6]`==`ALARM_TIME[16:6]`, and `CUR_TIME[5:0]`==0.
  - On match → `RING`. A match that occurs in any other state is missed and is not deferred.
- `RING`: `ALARM_RING`=1. OK or `RING_TICKS` expiry → `RUN`. `ALARM_ARMED` stays 1, so the alarm fires again the next day. MODE/UP are ignored.
- Re-trigger guard: while `CUR_TIME[5:0]`==0 still matches after leaving `RING`, a new ring is suppressed until SEC changes.
- Single tick counter: shared by the `VIEW_ALM`, `RING` and `SNOOZE` timeouts, cleared on every state entry.
- `EDIT_FIELD` is 0 outside the `SET_*`/`ALM_*` states.

## Timing
- Reset values: state `RUN`, all 17-bit outputs 0, `FLAG`=000, `EDIT_FIELD`=0, `IS_SAVED_TIME`=0, `ALARM_ARMED`=0, `ALARM_RING`=0, tick counter 0.
- All outputs are registered. A button pulse at edge n gives the state, `FLAG` and `EDIT_*` change visible after edge n+1.
- `IS_SAVED_TIME` is high exactly one cycle, in the same cycle `FLAG` returns to 000. The time calculator loads on that cycle.
- Timeout: the exit occurs on the cycle the tick counter reaches `TICKS-1`. That gives exactly `VIEW_TICKS` or `RING_TICKS` cycles in the state.
- Match to `ALARM_RING`=1 latency: 1 cycle.
- `RESETN` asserted mid-edit discards `EDIT_TIME` without a commit strobe.

## Configuration
- `ALARM_SNOOZE_EN` defined:
  - DOWN in `RING` → `SNOOZE` (`ALARM_RING`=0, `FLAG`=000).
  - After `SNOOZE_TICKS` cycles → `RING` again.
  - OK in `SNOOZE` cancels → `RUN`.
- `ALARM_SNOOZE_EN` undefined: no `SNOOZE` state, and DOWN in `RING` is ignored.

## Test plan
- Set time:
  - Stimulus: reset; MODE; UP×3 from hour 10 AM; MODE; UP; OK.
  - Required: `FLAG`=010 during the edit; `IN_TIME` hour=1 with MERIDIAN toggled to 1 and min incremented; `IS_SAVED_TIME` one cycle; `FLAG`=000 after.
- Wraps:
  - Stimulus: DOWN at min 0; UP at sec 59.
  - Required: min=59 and sec=0, MERIDIAN unchanged.
- Alarm:
  - Stimulus: set alarm to 7:30 AM; drive `CUR_TIME`=7:30:00 AM.
  - Required: `ALARM_RING`=1 one cycle later; OK clears it; holding `CUR_TIME` does not re-ring.
- View:
  - Stimulus: UP from `RUN`.
  - Required: `FLAG`=001 for exactly 100 cycles, then 000.
- Priority/reset:
  - Stimulus: MODE+OK in the same cycle in `SET_MIN`; separately, assert `RESETN` mid-edit.
  - Required: the first advances to `SET_SEC` with no commit; the second sets all outputs to reset values immediately.
- Snooze (`ALARM_SNOOZE_EN` only):
  - Stimulus: DOWN while ringing.
  - Required: `ALARM_RING`=0 for 30000 cycles, then 1.
